// File: rtl/serial_add_controller_pkg.sv
// serial_add_controller_pkg: shared state encodings and default sizes for the serial adder.
`default_nettype none

package serial_add_controller_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: parallel-load, right-shift register with MSB serial input (load beats shift).
`default_nettype none

module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             sout
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= pin;
    end else if (shift) begin
      data_q <= {sin, data_q[WIDTH-1:1]};
    end
  end

  assign pout = data_q;
  assign sout = data_q[0];

endmodule

`default_nettype wire

// File: rtl/serial_add_controller.sv
// serial_add_controller: bit-serial add (LSB first, one bit per clock) over three shift registers.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement a-b.
`default_nettype none

module serial_add_controller
  import serial_add_controller_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;
  logic             s;
  logic             carry_d;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;
  logic [WIDTH-1:0] a_pout;
  logic [WIDTH-1:0] b_pout;
  logic             r_sout;
  logic             unused_ok;

  assign accept   = (state_q == S_IDLE) && start;
  assign shift_en = (state_q == S_SHIFT);
  assign last_bit = shift_en && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  assign s       = a_bit ^ b_bit ^ carry_q;
  assign carry_d = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift_en),
    .pin  (a),
    .sin  (1'b0),
    .pout (a_pout),
    .sout (a_bit)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift_en),
    .pin  (b_load),
    .sin  (1'b0),
    .pout (b_pout),
    .sout (b_bit)
  );

  // Result register clears on accept and collects sum bits from the MSB end.
  serial_shift_reg #(.WIDTH(WIDTH)) u_sum_reg (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift_en),
    .pin  ('0),
    .sin  (s),
    .pout (sum),
    .sout (r_sout)
  );

  assign unused_ok = ^{a_pout, b_pout, r_sout};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            carry_q <= carry_init;
            busy_q  <= 1'b1;
          end
        end
        S_SHIFT: begin
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= carry_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_controller.sv
// tb_serial_add_controller: directed vectors with hand-computed sums for the serial adder.
`default_nettype none

module tb_serial_add_controller;

  localparam int WIDTH = 8;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests_run;
  int tests_failed;

  serial_add_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub),
`endif
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Index 0 is the falling edge right after the accept edge; done must appear at index WIDTH.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic [7:0] es, input logic ec,
                        input int repulse_at);
    int nbusy;
    int ndone;
    int first_done;
    logic [7:0] got_sum;
    logic got_cout;
    nbusy = 0;
    ndone = 0;
    first_done = -1;
    got_sum = '0;
    got_cout = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
`ifdef SERIAL_ADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("[TB] note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (busy) nbusy++;
      if (done) begin
        if (ndone == 0) begin
          first_done = i;
          got_sum = sum;
          got_cout = cout;
        end
        ndone++;
      end
      if (i == repulse_at) begin
        start = 1'b1;
        a = 8'd100;
        b = 8'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, nbusy, WIDTH);
    check({tag, "_done_index"}, first_done, WIDTH);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_sum"}, got_sum, es);
    check({tag, "_cout"}, got_cout, ec);
    check({tag, "_sum_held"}, sum, es);
  endtask

  initial begin
    int ndone_rst;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    run_op("add_25_17", 8'd25, 8'd17, 1'b0, 8'd42, 1'b0, -1);
    run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, -1);
    run_op("add_255_1", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, -1);
    run_op("add_0_0", 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, -1);
    run_op("ignore_restart", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 3);
    run_op("add_130_140", 8'd130, 8'd140, 1'b0, 8'd14, 1'b1, -1);

    // Abort mid-operation: cout is 1 from the previous run and must drop with rst.
    @(negedge clk);
    start = 1'b1;
    a = 8'd10;
    b = 8'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    ndone_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    check("abort_no_done", ndone_rst, 0);
    run_op("after_abort_10_20", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, -1);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_7_5", 8'd7, 8'd5, 1'b1, 8'd2, 1'b1, -1);
    run_op("sub_5_7", 8'd5, 8'd7, 1'b1, 8'd254, 1'b0, -1);
    run_op("add_5_7", 8'd5, 8'd7, 1'b0, 8'd12, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
